mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter BEAT_BYTES, default 1, memory port width in bytes; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, width of the byte address.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request strobe, sampled only in IDLE.
REQ-006 SHALL have port sel_mem_operation  input  1  0 = load, 1 = store.
REQ-007 SHALL have port sel_mem_size  input  2  access size: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B.
REQ-008 SHALL have port sel_mem_extension  input  1  load only: 1 = sign-extend, 0 = zero-extend.
REQ-009 SHALL have port addr  input  ADDR_WIDTH  byte address of the access.
REQ-010 SHALL have port data_i  input  64  store data; the low bytes are used, per the access size.
REQ-011 SHALL have port data_o  output  64  load result, extended to 64 bits.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port busy  output  1  high from request acceptance until done.
REQ-014 SHALL have port misaligned  output  1  error flag; pulses together with done.
REQ-015 SHALL have port mem_addr  output  ADDR_WIDTH  memory beat address.
REQ-016 SHALL have port data_mem  output  8*BEAT_BYTES  memory write data.
REQ-017 SHALL have port write_mem  output  1  memory write enable.
REQ-018 SHALL have port mem_wstrb  output  BEAT_BYTES  byte-lane write strobes.
REQ-019 SHALL have port mem_o  input  8*BEAT_BYTES  memory read data; combinational from mem_addr and sampled at the same edge.

Function
REQ-020 SHALL implement the FSM states IDLE, ACCESS and DONE, with these transitions:
- IDLE -> ACCESS on start=1 for an aligned request;
- IDLE -> DONE on start=1 for a misaligned request;
- ACCESS -> DONE after the last beat;
- DONE -> IDLE unconditionally.
REQ-021 SHALL, on acceptance (edge E0), register addr, size, operation, extension and data_i; input changes after E0 have no effect.
REQ-022 SHALL define S = 2^sel_mem_size bytes; beat count N = max(1, S/BEAT_BYTES).
REQ-023 SHALL flag a request as misaligned when addr mod min(S, BEAT_BYTES*N) is nonzero, i.e. addr mod S is nonzero.
- For a misaligned request: no beat issued, write_mem stays 0, done=1 and misaligned=1 in the cycle after E0, data_o unchanged.
REQ-024 SHALL issue beats i = 0..N-1 on consecutive cycles after E0, one beat per cycle.
REQ-025 SHALL, when S >= BEAT_BYTES, drive on beat i:
- mem_addr = addr + i*BEAT_BYTES;
- mem_wstrb all ones;
- data_mem = data_i bytes [i*BEAT_BYTES +: BEAT_BYTES].
REQ-026 SHALL, when S < BEAT_BYTES, run one beat with the following values:
- mem_addr = addr with its low log2(BEAT_BYTES) bits cleared;
- lane offset L = addr mod BEAT_BYTES;
- data_i low S bytes placed at lanes L..L+S-1;
- mem_wstrb set only on lanes L..L+S-1.
REQ-027 SHALL assert write_mem only during store beats; loads and non-beat cycles drive write_mem=0 and mem_wstrb=0.
REQ-028 SHALL, on loads, capture mem_o lanes (per REQ-025/026) at each beat edge, little-endian: beat 0 fills the lowest bytes.
REQ-029 SHALL, at completion of a load, update data_o with the S-byte result extended as follows:
- sign-extended from bit 8*S-1 when sel_mem_extension=1;
- zero-extended otherwise;
- extension is irrelevant when S=8.
REQ-030 SHALL leave data_o unchanged by stores and misaligned requests; data_o holds its value until the next successful load.
REQ-031 SHALL give a latency of N+1 cycles from E0 to done=1 for aligned requests; done is high exactly one cycle (state DONE).
REQ-032 SHALL drive busy=1 in ACCESS and DONE, and busy=0 in IDLE.
REQ-033 SHALL ignore start while busy=1; start high in DONE is not accepted, and a new request needs start high in IDLE.
REQ-034 SHALL drive mem_addr=0 and data_mem=0 in IDLE and DONE.
REQ-035 SHALL wrap the address computation addr + i*BEAT_BYTES modulo 2^ADDR_WIDTH.

Reset
REQ-036 SHALL, while reset=0, immediately force:
- state IDLE;
- data_o=0, done=0, busy=0, misaligned=0;
- write_mem=0, mem_wstrb=0, mem_addr=0, data_mem=0.
REQ-037 SHALL abort any in-progress access on reset assertion; no further beats are issued and no done is produced for the aborted request.
REQ-038 SHALL accept a new request on the first rising edge with reset=1 and start=1.

Verification
REQ-039 SHALL cover, with BEAT_BYTES=1, an 8-byte store of 0x1122334455667788 at 0x100 -> 8 write beats at 0x100..0x107 with data 0x88..0x11; done asserted 9 cycles after E0.
REQ-040 SHALL cover, with BEAT_BYTES=1, a 1-byte load at 0x103 with sel_mem_extension=1 from memory byte 0x80 -> data_o=0xFFFFFFFFFFFFFF80; with sel_mem_extension=0 -> data_o=0x0000000000000080.
REQ-041 SHALL cover, with BEAT_BYTES=4, a 2-byte store of 0xBEEF at 0x206 -> one beat, mem_addr=0x204, mem_wstrb=4'b1100, data_mem=0xBEEF0000.
REQ-042 SHALL cover, with BEAT_BYTES=4, a 4-byte load at 0x102 -> misaligned=1 and done=1 one cycle after E0, write_mem never high, data_o unchanged.
REQ-043 SHALL cover, with BEAT_BYTES=4, reset=0 asserted during beat 1 of an 8-byte store -> all outputs 0 immediately, no further beats, no done; after reset release, a new 4-byte load at 0x0 completes normally in 2 cycles.
REQ-044 SHALL cover start pulsed in ACCESS and DONE during a running load -> ignored, exactly one done produced.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Sequences one load or store of 1/2/4/8 bytes onto a memory port that is
// BEAT_BYTES wide. A request is accepted in IDLE, registered, and then played
// out as one or more consecutive beats. Accesses narrower than the port use a
// single beat with lane strobes. Accesses wider than the port are split into
// little-endian beats. Misaligned requests skip the memory entirely and report
// an error together with done.
//
// Parameters
//   BEAT_BYTES  memory port width in bytes (1, 2, 4 or 8)
//   ADDR_WIDTH  byte address width (at least 3)
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   start                request strobe, only looked at in IDLE
//   sel_mem_operation    0 = load, 1 = store
//   sel_mem_size         0/1/2/3 -> 1/2/4/8 bytes
//   sel_mem_extension    loads: 1 = sign-extend, 0 = zero-extend
//   addr, data_i         request byte address and store data (low bytes used)
//   data_o               last successful load result, extended to 64 bits
//   done, misaligned     one-cycle completion pulse and its error flag
//   busy                 high from acceptance until done
//   mem_addr, data_mem   memory beat address and write data
//   write_mem, mem_wstrb memory write enable and byte-lane strobes
//   mem_o                memory read data, combinational from mem_addr
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int BEAT_BYTES = 1,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    sel_mem_operation,
  input  logic [1:0]              sel_mem_size,
  input  logic                    sel_mem_extension,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [63:0]             data_i,
  output logic [63:0]             data_o,
  output logic                    done,
  output logic                    busy,
  output logic                    misaligned,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [8*BEAT_BYTES-1:0] data_mem,
  output logic                    write_mem,
  output logic [BEAT_BYTES-1:0]   mem_wstrb,
  input  logic [8*BEAT_BYTES-1:0] mem_o
);

  localparam int         DW        = 8 * BEAT_BYTES;
  localparam int         BB_LOG    = $clog2(BEAT_BYTES);
  localparam logic [3:0] BB4       = 4'(BEAT_BYTES);
  // Selects the lane-offset bits of a byte address (zero for a 1-byte port).
  localparam logic [2:0] LANE_MASK = 3'(BEAT_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // addr mod S != 0
  function automatic logic is_misaligned(input logic [2:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return |a[2:0];
    endcase
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] sz,
                                         input logic sx);
    case (sz)
      2'd0:    return {{56{sx & v[7]}},  v[7:0]};
      2'd1:    return {{48{sx & v[15]}}, v[15:0]};
      2'd2:    return {{32{sx & v[31]}}, v[31:0]};
      default: return v;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              size_q, size_d;
  logic                    op_q, op_d;
  logic                    ext_q, ext_d;
  logic [63:0]             wdata_q, wdata_d;
  logic [3:0]              beat_q, beat_d;
  logic [63:0]             rdata_q, rdata_d;
  logic [63:0]             data_o_q, data_o_d;
  logic                    mis_q, mis_d;

  // ---------------------------------------------------------------------------
  // Beat geometry for the registered request
  // ---------------------------------------------------------------------------
  logic [3:0]            s_bytes;
  logic [3:0]            n_beats;
  logic                  last_beat;
  logic [3:0]            beat_scaled;
  logic [2:0]            byte_off;
  logic [2:0]            lane;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [63:0]           wbeat;
  logic [7:0]            strb8;
  logic [63:0]           rbeat;
  logic [63:0]           rmerged;

  // The two cases "S >= BEAT_BYTES" and "S < BEAT_BYTES" share one datapath:
  // wide accesses are aligned to the port, so their lane offset is zero, and
  // narrow accesses use a single beat, so their byte offset is zero. Each
  // beat therefore moves request bytes [byte_off..] to port lanes [lane..].
  always_comb begin
    s_bytes     = 4'd1 << size_q;
    n_beats     = (s_bytes >= BB4) ? (s_bytes >> BB_LOG) : 4'd1;
    last_beat   = (beat_q == n_beats - 4'd1);
    beat_scaled = beat_q << BB_LOG;
    byte_off    = beat_scaled[2:0];
    lane        = addr_q[2:0] & LANE_MASK;
    // Additions wrap naturally at ADDR_WIDTH bits.
    beat_addr   = (addr_q + ADDR_WIDTH'(byte_off)) & ~ADDR_WIDTH'(LANE_MASK);
    wbeat       = ((wdata_q & size_mask(size_q)) >> {byte_off, 3'b000}) << {lane, 3'b000};
    strb8       = (byte_mask(size_q) >> byte_off) << lane;
    rbeat       = (64'(mem_o) >> {lane, 3'b000}) << {byte_off, 3'b000};
    rmerged     = rdata_q | (rbeat & size_mask(size_q));
  end

  // ---------------------------------------------------------------------------
  // Next state and memory-port outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case statement so that no
    // path leaves it unassigned; otherwise synthesis would infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    op_d      = op_q;
    ext_d     = ext_q;
    wdata_d   = wdata_q;
    beat_d    = beat_q;
    rdata_d   = rdata_q;
    data_o_d  = data_o_q;
    mis_d     = mis_q;
    mem_addr  = '0;
    data_mem  = '0;
    write_mem = 1'b0;
    mem_wstrb = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = addr;
          size_d  = sel_mem_size;
          op_d    = sel_mem_operation;
          ext_d   = sel_mem_extension;
          wdata_d = data_i;
          beat_d  = 4'd0;
          rdata_d = 64'd0;
          mis_d   = is_misaligned(addr[2:0], sel_mem_size);
          state_d = mis_d ? S_DONE : S_ACCESS;
        end
      end

      S_ACCESS: begin
        mem_addr = beat_addr;
        data_mem = DW'(wbeat);
        if (op_q) begin
          write_mem = 1'b1;
          mem_wstrb = BEAT_BYTES'(strb8);
        end else begin
          rdata_d = rmerged;
        end
        if (last_beat) begin
          state_d = S_DONE;
          // The final beat is folded in here so data_o is valid while done is high.
          if (!op_q) data_o_d = extend(rmerged, size_q, ext_q);
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign misaligned = (state_q == S_DONE) && mis_q;
  assign data_o     = data_o_q;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so that every flop
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      size_q   <= 2'd0;
      op_q     <= 1'b0;
      ext_q    <= 1'b0;
      wdata_q  <= 64'd0;
      beat_q   <= 4'd0;
      rdata_q  <= 64'd0;
      data_o_q <= 64'd0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      op_q     <= op_d;
      ext_q    <= ext_d;
      wdata_q  <= wdata_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
      data_o_q <= data_o_d;
      mis_q    <= mis_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Two instances: u_dut1 with a 1-byte port (64-bit addresses) and u_dut4 with
// a 4-byte port (32-bit addresses), each backed by a small byte memory model.
// Stimulus pushes hand-computed write beats and completions into per-instance
// queues; monitors on the falling edge pop and compare whenever the DUT shows
// a write beat or done.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } beat_t;

  typedef struct {
    logic        mis;
    logic [63:0] data_o;
    int          lat;
  } done_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  beat_t bq1[$];
  beat_t bq4[$];
  done_t dq1[$];
  done_t dq4[$];
  int    e0_1 = 0;
  int    e0_4 = 0;

  // ---------------- DUT with 1-byte port ----------------
  logic        reset_1 = 1'b1, start_1 = 1'b0, op_1 = 1'b0, ext_1 = 1'b0;
  logic [1:0]  size_1 = 2'd0;
  logic [63:0] addr_1 = '0, data_i_1 = '0;
  logic [63:0] data_o_1, mem_addr_1;
  logic        done_1, busy_1, mis_1, write_mem_1;
  logic [7:0]  data_mem_1, mem_o_1;
  logic [0:0]  mem_wstrb_1;
  logic [7:0]  mem1 [1024];

  mem_access_unit #(.BEAT_BYTES(1), .ADDR_WIDTH(64)) u_dut1 (
    .clk(clk), .reset(reset_1), .start(start_1), .sel_mem_operation(op_1),
    .sel_mem_size(size_1), .sel_mem_extension(ext_1), .addr(addr_1),
    .data_i(data_i_1), .data_o(data_o_1), .done(done_1), .busy(busy_1),
    .misaligned(mis_1), .mem_addr(mem_addr_1), .data_mem(data_mem_1),
    .write_mem(write_mem_1), .mem_wstrb(mem_wstrb_1), .mem_o(mem_o_1)
  );

  // ---------------- DUT with 4-byte port ----------------
  logic        reset_4 = 1'b1, start_4 = 1'b0, op_4 = 1'b0, ext_4 = 1'b0;
  logic [1:0]  size_4 = 2'd0;
  logic [31:0] addr_4 = '0;
  logic [63:0] data_i_4 = '0;
  logic [63:0] data_o_4;
  logic [31:0] mem_addr_4;
  logic        done_4, busy_4, mis_4, write_mem_4;
  logic [31:0] data_mem_4, mem_o_4;
  logic [3:0]  mem_wstrb_4;
  logic [7:0]  mem4 [1024];

  mem_access_unit #(.BEAT_BYTES(4), .ADDR_WIDTH(32)) u_dut4 (
    .clk(clk), .reset(reset_4), .start(start_4), .sel_mem_operation(op_4),
    .sel_mem_size(size_4), .sel_mem_extension(ext_4), .addr(addr_4),
    .data_i(data_i_4), .data_o(data_o_4), .done(done_4), .busy(busy_4),
    .misaligned(mis_4), .mem_addr(mem_addr_4), .data_mem(data_mem_4),
    .write_mem(write_mem_4), .mem_wstrb(mem_wstrb_4), .mem_o(mem_o_4)
  );

  // ---------------- Memory models ----------------
  logic [9:0] a1, a4;
  always_comb begin
    a1      = mem_addr_1[9:0];
    a4      = mem_addr_4[9:0];
    mem_o_1 = mem1[a1];
    mem_o_4 = {mem4[10'(a4 + 10'd3)], mem4[10'(a4 + 10'd2)],
               mem4[10'(a4 + 10'd1)], mem4[a4]};
  end

  always @(posedge clk) begin
    if (write_mem_1 && mem_wstrb_1[0]) mem1[a1] <= data_mem_1;
    if (write_mem_4)
      for (int i = 0; i < 4; i++)
        if (mem_wstrb_4[i]) mem4[10'(a4 + 10'(i))] <= data_mem_4[8*i +: 8];
  end

  // ---------------- Helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] strb_mask(input logic [7:0] s);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  task automatic push_beat(input int b, input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] s);
    beat_t t;
    t.addr = a; t.data = d; t.strb = s;
    if (b == 1) bq1.push_back(t); else bq4.push_back(t);
  endtask

  task automatic push_done(input int b, input logic mis, input logic [63:0] d, input int lat);
    done_t t;
    t.mis = mis; t.data_o = d; t.lat = lat;
    if (b == 1) dq1.push_back(t); else dq4.push_back(t);
  endtask

  task automatic preset(input int b, input int a, input logic [7:0] v);
    if (b == 1) mem1[a] <= v; else mem4[a] <= v;
  endtask

  // Drive one request, keep start high for 'hold' falling edges after
  // acceptance, scramble the inputs after acceptance, and wait for idle.
  task automatic issue(input int b, input logic op, input logic [1:0] sz, input logic ext,
                       input logic [63:0] a, input logic [63:0] d, input int hold);
    bit ok = 0;
    @(negedge clk);
    if (b == 1) begin
      op_1 = op; size_1 = sz; ext_1 = ext; addr_1 = a; data_i_1 = d; start_1 = 1'b1;
      e0_1 = cyc + 1;
    end else begin
      op_4 = op; size_4 = sz; ext_4 = ext; addr_4 = 32'(a); data_i_4 = d; start_4 = 1'b1;
      e0_4 = cyc + 1;
    end
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (b == 1) begin
          op_1 = ~op; size_1 = ~sz; ext_1 = ~ext; addr_1 = ~a; data_i_1 = ~d;
        end else begin
          op_4 = ~op; size_4 = ~sz; ext_4 = ~ext; addr_4 = ~32'(a); data_i_4 = ~d;
        end
      end
      if (k >= hold) begin
        if (b == 1) start_1 = 1'b0; else start_4 = 1'b0;
      end
      if ((b == 1) ? !busy_1 : !busy_4) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL timeout_dut%0d: busy still high after 40 cycles, expected idle", b);
    end
  endtask

  // ---------------- Monitors ----------------
  always @(negedge clk) begin
    beat_t bt;
    done_t dn;
    if (write_mem_1) begin
      if (bq1.size() == 0) begin
        checks++; failures++;
        $display("FAIL beat1_unexpected: got write at %h, expected none", mem_addr_1);
      end else begin
        bt = bq1.pop_front();
        check("beat1_addr", mem_addr_1, bt.addr);
        check("beat1_strb", 64'(mem_wstrb_1), 64'(bt.strb));
        check("beat1_data", 64'(data_mem_1) & strb_mask(8'(mem_wstrb_1)), bt.data);
      end
    end
    if (done_1) begin
      if (dq1.size() == 0) begin
        checks++; failures++;
        $display("FAIL done1_unexpected: got done, expected none");
      end else begin
        dn = dq1.pop_front();
        check("done1_mis", 64'(mis_1), 64'(dn.mis));
        check("done1_data_o", data_o_1, dn.data_o);
        check("done1_latency", 64'(cyc - e0_1 + 1), 64'(dn.lat));
      end
    end
  end

  always @(negedge clk) begin
    beat_t bt;
    done_t dn;
    if (write_mem_4) begin
      if (bq4.size() == 0) begin
        checks++; failures++;
        $display("FAIL beat4_unexpected: got write at %h, expected none", mem_addr_4);
      end else begin
        bt = bq4.pop_front();
        check("beat4_addr", 64'(mem_addr_4), bt.addr);
        check("beat4_strb", 64'(mem_wstrb_4), 64'(bt.strb));
        check("beat4_data", 64'(data_mem_4) & strb_mask(8'(mem_wstrb_4)), bt.data);
      end
    end
    if (done_4) begin
      if (dq4.size() == 0) begin
        checks++; failures++;
        $display("FAIL done4_unexpected: got done, expected none");
      end else begin
        dn = dq4.pop_front();
        check("done4_mis", 64'(mis_4), 64'(dn.mis));
        check("done4_data_o", data_o_4, dn.data_o);
        check("done4_latency", 64'(cyc - e0_4 + 1), 64'(dn.lat));
      end
    end
  end

  // ---------------- Stimulus ----------------
  initial begin
    #2;
    reset_1 = 1'b0;
    reset_4 = 1'b0;
    #1;
    check("rst1_data_o", data_o_1, 64'd0);
    check("rst1_busy", 64'(busy_1), 64'd0);
    check("rst1_done", 64'(done_1), 64'd0);
    check("rst1_write_mem", 64'(write_mem_1), 64'd0);
    check("rst4_data_o", data_o_4, 64'd0);
    check("rst4_busy", 64'(busy_4), 64'd0);
    check("rst4_mem_addr", 64'(mem_addr_4), 64'd0);
    check("rst4_wstrb", 64'(mem_wstrb_4), 64'd0);
    @(negedge clk);
    preset(1, 'h103, 8'h80);
    preset(1, 'h200, 8'h34);
    preset(1, 'h201, 8'hA2);
    for (int i = 0; i < 8; i++) preset(4, 'h100 + i, 8'(8'h11 * (i + 1)));
    @(posedge clk);
    #1;
    reset_1 = 1'b1;
    reset_4 = 1'b1;

    // ----- 1-byte port -----
    push_done(1, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 2);
    issue(1, 1'b0, 2'd0, 1'b1, 64'h103, 64'h0, 1);
    push_done(1, 1'b0, 64'h0000_0000_0000_0080, 2);
    issue(1, 1'b0, 2'd0, 1'b0, 64'h103, 64'h0, 1);

    for (int i = 0; i < 8; i++)
      push_beat(1, 64'h100 + 64'(i), 64'((64'h88 - 64'(i) * 64'h11)), 8'h01);
    push_done(1, 1'b0, 64'h0000_0000_0000_0080, 9);
    issue(1, 1'b1, 2'd3, 1'b0, 64'h100, 64'h1122_3344_5566_7788, 1);

    push_done(1, 1'b0, 64'h1122_3344_5566_7788, 9);
    issue(1, 1'b0, 2'd3, 1'b1, 64'h100, 64'h0, 1);

    push_done(1, 1'b1, 64'h1122_3344_5566_7788, 1);
    issue(1, 1'b0, 2'd1, 1'b0, 64'h101, 64'h0, 1);

    // start held high through ACCESS and DONE
    push_done(1, 1'b0, 64'hFFFF_FFFF_FFFF_A234, 3);
    issue(1, 1'b0, 2'd1, 1'b1, 64'h200, 64'h0, 4);
    repeat (3) @(negedge clk);
    check("dut1_idle_after_held_start", 64'(busy_1), 64'd0);

    push_done(1, 1'b0, 64'h0000_0000_1122_3344, 5);
    issue(1, 1'b0, 2'd2, 1'b0, 64'h104, 64'h0, 1);

    push_done(1, 1'b1, 64'h0000_0000_1122_3344, 1);
    issue(1, 1'b1, 2'd2, 1'b0, 64'h106, 64'hFFFF_FFFF_FFFF_FFFF, 1);

    // ----- 4-byte port -----
    push_beat(4, 64'h204, 64'h0000_0000_BEEF_0000, 8'h0C);
    push_done(4, 1'b0, 64'h0, 2);
    issue(4, 1'b1, 2'd1, 1'b0, 64'h206, 64'hFFFF_FFFF_FFFF_BEEF, 1);

    push_done(4, 1'b0, 64'h0000_0000_4433_2211, 2);
    issue(4, 1'b0, 2'd2, 1'b1, 64'h100, 64'h0, 1);

    push_done(4, 1'b1, 64'h0000_0000_4433_2211, 1);
    issue(4, 1'b0, 2'd2, 1'b0, 64'h102, 64'h0, 1);

    push_done(4, 1'b0, 64'h8877_6655_4433_2211, 3);
    issue(4, 1'b0, 2'd3, 1'b1, 64'h100, 64'h0, 1);

    push_done(4, 1'b0, 64'hFFFF_FFFF_FFFF_FFBE, 2);
    issue(4, 1'b0, 2'd0, 1'b1, 64'h207, 64'h0, 1);

    push_done(4, 1'b0, 64'h0000_0000_0000_BEEF, 2);
    issue(4, 1'b0, 2'd1, 1'b0, 64'h206, 64'h0, 1);

    push_beat(4, 64'h300, 64'h0000_0000_0000_5A00, 8'h02);
    push_done(4, 1'b0, 64'h0000_0000_0000_BEEF, 2);
    issue(4, 1'b1, 2'd0, 1'b0, 64'h301, 64'hFFFF_FFFF_FFFF_FF5A, 1);

    // Reset during beat 1 of an 8-byte store
    push_beat(4, 64'h300, 64'h0000_0000_1234_5678, 8'h0F);
    @(negedge clk);
    op_4 = 1'b1; size_4 = 2'd3; ext_4 = 1'b0; addr_4 = 32'h300;
    data_i_4 = 64'hCAFE_F00D_1234_5678; start_4 = 1'b1; e0_4 = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    start_4 = 1'b0;
    @(posedge clk);
    #1;
    reset_4 = 1'b0;
    #1;
    check("abort_write_mem", 64'(write_mem_4), 64'd0);
    check("abort_mem_addr", 64'(mem_addr_4), 64'd0);
    check("abort_data_mem", 64'(data_mem_4), 64'd0);
    check("abort_wstrb", 64'(mem_wstrb_4), 64'd0);
    check("abort_busy", 64'(busy_4), 64'd0);
    check("abort_done", 64'(done_4), 64'd0);
    check("abort_mis", 64'(mis_4), 64'd0);
    check("abort_data_o", data_o_4, 64'd0);
    repeat (4) @(negedge clk);
    check("abort_still_idle", 64'(busy_4), 64'd0);
    preset(4, 0, 8'hF0);
    preset(4, 1, 8'hDE);
    preset(4, 2, 8'hBC);
    preset(4, 3, 8'h9A);
    @(posedge clk);
    #1;
    reset_4 = 1'b1;
    push_done(4, 1'b0, 64'h0000_0000_9ABC_DEF0, 2);
    issue(4, 1'b0, 2'd2, 1'b0, 64'h0, 64'h0, 1);
    push_done(4, 1'b0, 64'hFFFF_FFFF_9ABC_DEF0, 2);
    issue(4, 1'b0, 2'd2, 1'b1, 64'h0, 64'h0, 1);

    repeat (4) @(negedge clk);
    check("beat1_queue_empty", 64'(bq1.size()), 64'd0);
    check("done1_queue_empty", 64'(dq1.size()), 64'd0);
    check("beat4_queue_empty", 64'(bq4.size()), 64'd0);
    check("done4_queue_empty", 64'(dq4.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
